// File: rtl/dmem_arb_pkg.sv
// Shared types and decode helpers for the two-port data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } state_e;

  // RISC-V funct3 load/store size codes
  typedef enum logic [2:0] {
    SizeB   = 3'b000,
    SizeH   = 3'b001,
    SizeW   = 3'b010,
    SizeD   = 3'b011,
    SizeBu  = 3'b100,
    SizeHu  = 3'b101,
    SizeWu  = 3'b110,
    SizeIll = 3'b111
  } size_e;

  function automatic logic [7:0] size_to_be(input logic [2:0] size);
    logic [7:0] be;
    unique case (size[1:0])
      2'b00:   be = 8'h01;
      2'b01:   be = 8'h03;
      2'b10:   be = 8'h0F;
      default: be = 8'hFF;
    endcase
    return be;
  endfunction

  // size[2] selects zero extension; otherwise the top loaded bit is replicated
  function automatic logic [63:0] load_extend(input logic [2:0] size, input logic [63:0] data);
    logic [63:0] res;
    logic        sx;
    sx = ~size[2];
    unique case (size[1:0])
      2'b00:   res = {{56{sx & data[7]}}, data[7:0]};
      2'b01:   res = {{48{sx & data[15]}}, data[15:0]};
      2'b10:   res = {{32{sx & data[31]}}, data[31:0]};
      default: res = data;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-requester round-robin picker; the last-grant history is held by the caller.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_gnt,
  input  logic       en,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_gnt ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and one-access sequencer sharing dmem between the LSU and debug ports.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MEM_SIZE = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_i,
  input  logic [1:0]  we_i,
  input  logic [63:0] addr_i [2],
  input  logic [63:0] wdata_i [2],
  input  logic [2:0]  size_i [2],
  output logic [1:0]  gnt_o,
  output logic [1:0]  rvalid_o,
  output logic [63:0] rdata_o,
  output logic        err_o,
  output logic [63:0] mem_addr_o,
  output logic [63:0] mem_wdata_o,
  output logic [7:0]  mem_byte_en_o,
  output logic        mem_wen_o,
  input  logic [63:0] mem_rdata_i
);

  state_e      r_state, w_state_next;
  logic        r_last_gnt;
  logic        r_port;
  logic        r_we;
  logic [63:0] r_addr;
  logic [63:0] r_wdata;
  logic [2:0]  r_size;
  logic [1:0]  r_rvalid;
  logic [63:0] r_rdata;
  logic        r_err;

  logic        w_en;
  logic [1:0]  w_gnt;
  logic        w_sel;
  logic [3:0]  w_nbytes;
  logic [2:0]  w_mask;
  logic [64:0] w_end;
  logic        w_misalign, w_oor, w_illegal, w_err;

  // Arbitration is suppressed while reset is held so no grant is shown for a dropped capture
  assign w_en  = ~rst & ((r_state == StIdle) | (r_state == StResp));
  assign w_sel = w_gnt[1];

  rr_arb2 u_rr_arb2 (
    .req      (req_i),
    .last_gnt (r_last_gnt),
    .en       (w_en),
    .gnt      (w_gnt)
  );

  assign gnt_o = w_gnt;

  assign w_nbytes   = 4'd1 << r_size[1:0];
  assign w_mask     = 3'(w_nbytes - 4'd1);
  assign w_misalign = |(r_addr[2:0] & w_mask);
  assign w_end      = {1'b0, r_addr} + {61'd0, w_nbytes};
  assign w_oor      = w_end > 65'(MEM_SIZE);
  assign w_illegal  = (r_size == SizeIll) | (r_we & r_size[2]);
  assign w_err      = w_misalign | w_oor | w_illegal;

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:   if (|w_gnt) w_state_next = StAccess;
      StAccess: w_state_next = StResp;
      StResp:   w_state_next = (|w_gnt) ? StAccess : StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  always_comb begin
    mem_addr_o    = '0;
    mem_wdata_o   = '0;
    mem_byte_en_o = '0;
    mem_wen_o     = 1'b0;
    if ((r_state == StAccess) && !w_err) begin
      mem_addr_o    = r_addr;
      mem_wdata_o   = r_wdata;
      mem_byte_en_o = size_to_be(r_size);
      mem_wen_o     = r_we;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_last_gnt <= 1'b1;
      r_port     <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_size     <= '0;
      r_rvalid   <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_rvalid <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
      if (|w_gnt) begin
        r_last_gnt <= w_sel;
        r_port     <= w_sel;
        r_we       <= we_i[w_sel];
        r_addr     <= addr_i[w_sel];
        r_wdata    <= wdata_i[w_sel];
        r_size     <= size_i[w_sel];
      end
      if (r_state == StAccess) begin
        r_rvalid <= r_port ? 2'b10 : 2'b01;
        r_err    <= w_err;
        r_rdata  <= (w_err | r_we) ? '0 : load_extend(r_size, mem_rdata_i);
      end
    end
  end

  assign rvalid_o = r_rvalid;
  assign rdata_o  = r_rdata;
  assign err_o    = r_err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter: a byte-array memory plus a transaction-level reference model.
module tb_dmem_arbiter;

  localparam int unsigned MEM_SIZE = 4096;

  logic        clk;
  logic        rst;
  logic [1:0]  req_i;
  logic [1:0]  we_i;
  logic [63:0] addr_i [2];
  logic [63:0] wdata_i [2];
  logic [2:0]  size_i [2];
  logic [1:0]  gnt_o;
  logic [1:0]  rvalid_o;
  logic [63:0] rdata_o;
  logic        err_o;
  logic [63:0] mem_addr_o;
  logic [63:0] mem_wdata_o;
  logic [7:0]  mem_byte_en_o;
  logic        mem_wen_o;
  logic [63:0] mem_rdata_i;

  dmem_arbiter #(
    .MEM_SIZE (MEM_SIZE)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_i         (req_i),
    .we_i          (we_i),
    .addr_i        (addr_i),
    .wdata_i       (wdata_i),
    .size_i        (size_i),
    .gnt_o         (gnt_o),
    .rvalid_o      (rvalid_o),
    .rdata_o       (rdata_o),
    .err_o         (err_o),
    .mem_addr_o    (mem_addr_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_byte_en_o (mem_byte_en_o),
    .mem_wen_o     (mem_wen_o),
    .mem_rdata_i   (mem_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Attached memory: combinational read, byte-enabled write on the clock edge
  logic [7:0] dmem [MEM_SIZE] = '{default: 8'h00};

  always_comb begin
    mem_rdata_i = '0;
    for (int k = 0; k < 8; k++) begin
      if ((65'(mem_addr_o) + 65'(k)) < 65'(MEM_SIZE)) begin
        mem_rdata_i[8*k +: 8] = dmem[12'(mem_addr_o + 64'(k))];
      end
    end
  end

  always @(posedge clk) begin
    if (mem_wen_o) begin
      for (int k = 0; k < 8; k++) begin
        if (mem_byte_en_o[k]) dmem[12'(mem_addr_o + 64'(k))] <= mem_wdata_o[8*k +: 8];
      end
    end
  end

  // Reference model state
  logic [7:0]  ref_mem [MEM_SIZE] = '{default: 8'h00};
  int          n_tests;
  int          n_fail;
  int          cyc;
  int          next_free;
  int          last_g;
  logic [1:0]  pv;
  logic [1:0]  pwe;
  logic [63:0] paddr [2];
  logic [63:0] pwdata [2];
  logic [2:0]  psize [2];
  logic        acc_v [4];
  logic [7:0]  acc_be [4];
  logic        acc_wen [4];
  logic [63:0] acc_addr [4];
  logic        rsp_v [4];
  int          rsp_port [4];
  logic        rsp_err [4];
  logic [63:0] rsp_data [4];
  logic [1:0]  obs_gnt;
  logic [7:0]  obs_be;
  logic [63:0] last_rdata;
  logic        last_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic ref_err(input logic w, input logic [63:0] a, input logic [2:0] s);
    int unsigned n;
    logic [64:0] e;
    n = 1 << s[1:0];
    e = 65'(a) + 65'(n);
    return ((a % 64'(n)) != 64'd0) || (e > 65'(MEM_SIZE)) || (s == 3'b111) || (w && s[2]);
  endfunction

  function automatic logic [63:0] ref_load(input logic [63:0] a, input logic [2:0] s);
    int          n;
    logic [63:0] v;
    n = 1 << s[1:0];
    v = '0;
    for (int k = 0; k < n; k++) v = v | (64'(ref_mem[12'(a + 64'(k))]) << (8 * k));
    if (!s[2] && n < 8 && v[8*n-1]) v = v | (~64'd0 << (8 * n));
    return v;
  endfunction

  task automatic clear_model();
    cyc       = 0;
    next_free = 0;
    last_g    = 1;
    for (int i = 0; i < 4; i++) begin
      acc_v[i] = 1'b0;
      rsp_v[i] = 1'b0;
    end
  endtask

  // One clock: drive pending requests, check every output against the model, advance the model
  task automatic step();
    logic [1:0] eg;
    int         g;
    int         n;
    int         s;
    int         sa;
    int         sr;
    logic       e;
    @(negedge clk);
    rst   = 1'b0;
    req_i = pv;
    we_i  = pwe;
    for (int p = 0; p < 2; p++) begin
      addr_i[p]  = paddr[p];
      wdata_i[p] = pwdata[p];
      size_i[p]  = psize[p];
    end
    #1;
    eg = 2'b00;
    if (cyc >= next_free) eg = (pv == 2'b11) ? ((last_g == 1) ? 2'b01 : 2'b10) : pv;
    check("gnt", 64'(gnt_o), 64'(eg));
    obs_gnt = gnt_o;
    s = cyc % 4;
    if (acc_v[s]) begin
      check("byte_en", 64'(mem_byte_en_o), 64'(acc_be[s]));
      check("mem_wen", 64'(mem_wen_o), 64'(acc_wen[s]));
      if (acc_be[s] != 8'h00) check("mem_addr", mem_addr_o, acc_addr[s]);
      obs_be   = mem_byte_en_o;
      acc_v[s] = 1'b0;
    end else begin
      check("idle_wen", 64'(mem_wen_o), 64'd0);
      check("idle_be", 64'(mem_byte_en_o), 64'd0);
    end
    if (rsp_v[s]) begin
      check("rvalid", 64'(rvalid_o), (rsp_port[s] == 1) ? 64'd2 : 64'd1);
      check("rdata", rdata_o, rsp_data[s]);
      check("err", 64'(err_o), 64'(rsp_err[s]));
      last_rdata = rdata_o;
      last_err   = err_o;
      rsp_v[s]   = 1'b0;
    end else begin
      check("rvalid_idle", 64'(rvalid_o), 64'd0);
    end
    if (eg != 2'b00) begin
      g  = eg[1] ? 1 : 0;
      n  = 1 << psize[g][1:0];
      e  = ref_err(pwe[g], paddr[g], psize[g]);
      sa = (cyc + 1) % 4;
      sr = (cyc + 2) % 4;
      acc_v[sa]    = 1'b1;
      acc_be[sa]   = e ? 8'h00 : 8'((16'd1 << n) - 16'd1);
      acc_wen[sa]  = !e && pwe[g];
      acc_addr[sa] = paddr[g];
      rsp_v[sr]    = 1'b1;
      rsp_port[sr] = g;
      rsp_err[sr]  = e;
      rsp_data[sr] = (e || pwe[g]) ? 64'd0 : ref_load(paddr[g], psize[g]);
      if (pwe[g] && !e) begin
        for (int k = 0; k < n; k++) ref_mem[12'(paddr[g] + 64'(k))] = pwdata[g][8*k +: 8];
      end
      last_g    = g;
      next_free = cyc + 2;
      pv[g]     = 1'b0;
    end
    cyc++;
  endtask

  task automatic issue(input int p, input logic w, input logic [63:0] a, input logic [63:0] d,
                       input logic [2:0] s);
    pv[p]     = 1'b1;
    pwe[p]    = w;
    paddr[p]  = a;
    pwdata[p] = d;
    psize[p]  = s;
    for (int i = 0; i < 10 && pv[p]; i++) step();
    if (pv[p]) begin
      check("issue_timeout", 64'(pv[p]), 64'd0);
      pv[p] = 1'b0;
    end
    step();
    step();
  endtask

  task automatic reset_dut(input int n, input logic in_access);
    @(negedge clk);
    rst   = 1'b1;
    pv    = 2'b00;
    req_i = 2'b00;
    #1;
    if (in_access) check("rst_acc_be", 64'(mem_byte_en_o), 64'hFF);
    for (int i = 1; i < n; i++) @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_gnt", 64'(gnt_o), 64'd0);
    check("rst_rvalid", 64'(rvalid_o), 64'd0);
    check("rst_rdata", rdata_o, 64'd0);
    check("rst_err", 64'(err_o), 64'd0);
    check("rst_wen", 64'(mem_wen_o), 64'd0);
    check("rst_be", 64'(mem_byte_en_o), 64'd0);
    check("rst_maddr", mem_addr_o, 64'd0);
    check("rst_mwdata", mem_wdata_o, 64'd0);
    clear_model();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int         ng;
  int         glog [4];
  int         gcyc [4];
  int         r;
  int         nb;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    req_i   = '0;
    we_i    = '0;
    pv      = '0;
    pwe     = '0;
    obs_be  = '0;
    for (int p = 0; p < 2; p++) begin
      addr_i[p]  = '0;
      wdata_i[p] = '0;
      size_i[p]  = '0;
      paddr[p]   = '0;
      pwdata[p]  = '0;
      psize[p]   = '0;
    end
    clear_model();
    reset_dut(2, 1'b0);

    issue(0, 1'b1, 64'd16, 64'h8877665544332211, 3'b011);
    check("sd_err", 64'(last_err), 64'd0);
    issue(0, 1'b0, 64'd16, 64'd0, 3'b011);
    check("ld16", last_rdata, 64'h8877665544332211);
    check("ld16_err", 64'(last_err), 64'd0);
    issue(0, 1'b0, 64'd23, 64'd0, 3'b000);
    check("lb23", last_rdata, 64'hFFFF_FFFF_FFFF_FF88);
    issue(0, 1'b0, 64'd23, 64'd0, 3'b100);
    check("lbu23", last_rdata, 64'h88);
    issue(0, 1'b0, 64'd16, 64'd0, 3'b010);
    check("lw16", last_rdata, 64'h0000_0000_4433_2211);

    issue(0, 1'b1, 64'd18, 64'hDEAD, 3'b010);
    check("sw18_err", 64'(last_err), 64'd1);
    check("sw18_rdata", last_rdata, 64'd0);
    issue(0, 1'b1, 64'd4092, 64'hBEEF, 3'b011);
    check("sd4092_err", 64'(last_err), 64'd1);
    issue(0, 1'b0, 64'd4088, 64'd0, 3'b011);
    check("ld4088_err", 64'(last_err), 64'd0);

    issue(0, 1'b1, 64'd2, 64'hFFFF_FFFF_FFFF_AABB, 3'b001);
    check("sh_be", 64'(obs_be), 64'h03);
    issue(0, 1'b0, 64'd0, 64'd0, 3'b011);
    check("ld0_after_sh", last_rdata, 64'h0000_0000_AABB_0000);

    // Both ports held requesting from reset: alternation starts at port 0
    reset_dut(1, 1'b0);
    ng = 0;
    for (int i = 0; i < 12 && ng < 4; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pv[p]) begin
          pv[p]    = 1'b1;
          pwe[p]   = 1'b0;
          paddr[p] = (p == 0) ? 64'd32 : 64'd40;
          psize[p] = 3'b011;
        end
      end
      step();
      if (obs_gnt != 2'b00) begin
        glog[ng] = obs_gnt[1] ? 1 : 0;
        gcyc[ng] = cyc - 1;
        ng++;
      end
    end
    check("tie_count", 64'(ng), 64'd4);
    for (int k = 0; k < ng; k++) begin
      check("tie_port", 64'(glog[k]), 64'(k % 2));
      if (k > 0) check("tie_spacing", 64'(gcyc[k] - gcyc[k-1]), 64'd2);
    end
    pv = 2'b00;
    for (int i = 0; i < 3; i++) step();

    // Reset while a port-0 load is in its access cycle
    pv[0] = 1'b1; pwe[0] = 1'b0; paddr[0] = 64'd8; psize[0] = 3'b011;
    step();
    check("rst_load_gnt", 64'(obs_gnt), 64'd1);
    reset_dut(1, 1'b1);
    step();
    pv = 2'b11;
    paddr[0] = 64'd8;  pwe[0] = 1'b0; psize[0] = 3'b011;
    paddr[1] = 64'd24; pwe[1] = 1'b0; psize[1] = 3'b011;
    step();
    check("post_rst_tie", 64'(obs_gnt), 64'd1);
    for (int i = 0; i < 4; i++) step();

    for (int it = 0; it < 1500; it++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pv[p] && $urandom_range(0, 3) != 0) begin
          pv[p]     = 1'b1;
          pwe[p]    = 1'($urandom_range(0, 1));
          psize[p]  = 3'($urandom_range(0, 7));
          pwdata[p] = {$urandom, $urandom};
          r = $urandom_range(0, 9);
          if (r < 7)      paddr[p] = 64'($urandom_range(0, 63));
          else if (r < 9) paddr[p] = 64'(4080 + $urandom_range(0, 15));
          else            paddr[p] = {$urandom, $urandom};
          nb = 1 << psize[p][1:0];
          if ($urandom_range(0, 1) == 1) paddr[p] = paddr[p] & ~64'(nb - 1);
        end
      end
      step();
    end
    pv = 2'b00;
    for (int i = 0; i < 4; i++) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
